// File: rtl/branch_predictor.sv
// Branch target buffer with 2-bit saturating direction counters and a mispredict counter.
// Optional gshare counter indexing is enabled by defining BRANCH_PREDICTOR_GSHARE_EN.
module branch_predictor #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned GHR_W   = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush_tbl,
    input  logic [XLEN-1:0] lk_pc,
    output logic            lk_hit,
    output logic            lk_taken,
    output logic [XLEN-1:0] lk_target,
    input  logic            up_valid,
    input  logic [XLEN-1:0] up_pc,
    input  logic            up_is_jump,
    input  logic            up_taken,
    input  logic [XLEN-1:0] up_target,
    input  logic            up_mispredict,
    output logic [CNT_W-1:0] mispredict_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] jump_q, jump_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [XLEN-1:0]    target_q [ENTRIES];
    logic [XLEN-1:0]    target_d [ENTRIES];
    logic [1:0]         ctr_q    [ENTRIES];
    logic [1:0]         ctr_d    [ENTRIES];
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [IDX_W-1:0] lk_idx, up_idx, lk_cidx, up_cidx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;

    assign lk_idx = lk_pc[IDX_W+1:2];
    assign lk_tag = lk_pc[XLEN-1:IDX_W+2];
    assign up_idx = up_pc[IDX_W+1:2];
    assign up_tag = up_pc[XLEN-1:IDX_W+2];

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    // Direction counters are indexed by PC xor global history; BTB fields stay PC-indexed.
    assign lk_cidx = lk_idx ^ IDX_W'(ghr_q);
    assign up_cidx = up_idx ^ IDX_W'(ghr_q);

    always_comb begin
        ghr_d = ghr_q;
        if (up_valid && !up_is_jump) begin
            ghr_d = GHR_W'({ghr_q, up_taken});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end
`else
    assign lk_cidx = lk_idx;
    assign up_cidx = up_idx;
`endif

    logic unused_c;
    assign unused_c = ^{lk_pc[1:0], up_pc[1:0], 1'(GHR_W)};

    // Lookup sees only registered state, so same-cycle updates are not bypassed.
    always_comb begin
        lk_hit    = !reset && valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
        lk_taken  = lk_hit && (jump_q[lk_idx] || ctr_q[lk_cidx][1]);
        lk_target = lk_hit ? target_q[lk_idx] : '0;
    end

    assign up_hit         = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign mispredict_cnt = cnt_q;

    // Table update; flush wins over a concurrent update.
    always_comb begin
        valid_d  = valid_q;
        jump_d   = jump_q;
        tag_d    = tag_q;
        target_d = target_q;
        ctr_d    = ctr_q;
        if (flush_tbl) begin
            valid_d = '0;
        end else if (up_valid) begin
            if (up_hit) begin
                if (up_taken) begin
                    if (ctr_q[up_cidx] != 2'd3) begin
                        ctr_d[up_cidx] = ctr_q[up_cidx] + 2'd1;
                    end
                    target_d[up_idx] = up_target;
                    jump_d[up_idx]   = up_is_jump;
                end else if (ctr_q[up_cidx] != 2'd0) begin
                    ctr_d[up_cidx] = ctr_q[up_cidx] - 2'd1;
                end
            end else if (up_taken) begin
                valid_d[up_idx]  = 1'b1;
                tag_d[up_idx]    = up_tag;
                target_d[up_idx] = up_target;
                jump_d[up_idx]   = up_is_jump;
                ctr_d[up_cidx]   = up_is_jump ? 2'd3 : 2'd2;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (up_valid && up_mispredict && (cnt_q != '1)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            jump_q  <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < int'(ENTRIES); i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'd1;
            end
        end else begin
            valid_q  <= valid_d;
            jump_q   <= jump_d;
            cnt_q    <= cnt_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            ctr_q    <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=16, CNT_W=4).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_tbl;
    logic [31:0] lk_pc;
    logic        lk_hit;
    logic        lk_taken;
    logic [31:0] lk_target;
    logic        up_valid;
    logic [31:0] up_pc;
    logic        up_is_jump;
    logic        up_taken;
    logic [31:0] up_target;
    logic        up_mispredict;
    logic [3:0]  mispredict_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predictor #(.XLEN(32), .ENTRIES(16), .GHR_W(4), .CNT_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_tbl      (flush_tbl),
        .lk_pc          (lk_pc),
        .lk_hit         (lk_hit),
        .lk_taken       (lk_taken),
        .lk_target      (lk_target),
        .up_valid       (up_valid),
        .up_pc          (up_pc),
        .up_is_jump     (up_is_jump),
        .up_taken       (up_taken),
        .up_target      (up_target),
        .up_mispredict  (up_mispredict),
        .mispredict_cnt (mispredict_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives one update for a single clock edge, then idles the update port.
    task automatic update(input logic [31:0] pc, input logic jmp, input logic tkn,
                          input logic [31:0] tgt, input logic mis);
        up_valid      = 1'b1;
        up_pc         = pc;
        up_is_jump    = jmp;
        up_taken      = tkn;
        up_target     = tgt;
        up_mispredict = mis;
        @(posedge clk);
        #1;
        up_valid      = 1'b0;
        up_mispredict = 1'b0;
    endtask

    task automatic look(input logic [31:0] pc);
        lk_pc = pc;
        #1;
    endtask

    initial begin
        reset = 1'b1; flush_tbl = 1'b0; lk_pc = 32'h40;
        up_valid = 1'b0; up_pc = '0; up_is_jump = 1'b0; up_taken = 1'b0;
        up_target = '0; up_mispredict = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("in_reset_hit", 32'(lk_hit), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        look(32'h40);
        check("rst_hit", 32'(lk_hit), 32'd0);
        check("rst_taken", 32'(lk_taken), 32'd0);
        check("rst_target", lk_target, 32'd0);
        check("rst_cnt", 32'(mispredict_cnt), 32'd0);

        // Allocate a taken branch: ctr=2
        update(32'h40, 1'b0, 1'b1, 32'h100, 1'b1);
        look(32'h40);
        check("alloc_hit", 32'(lk_hit), 32'd1);
        check("alloc_taken", 32'(lk_taken), 32'd1);
        check("alloc_target", lk_target, 32'h100);
        check("alloc_cnt", 32'(mispredict_cnt), 32'd1);

        // Walk 2->1->0->0, then back up 0->1->2
        update(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("ctr1_taken", 32'(lk_taken), 32'd0);
        check("ctr1_hit", 32'(lk_hit), 32'd1);
        update(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        update(32'h40, 1'b0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("ctr0_taken", 32'(lk_taken), 32'd0);
        check("ctr0_hit", 32'(lk_hit), 32'd1);
        update(32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        check("ctr_floor_taken", 32'(lk_taken), 32'd0);
        update(32'h40, 1'b0, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        check("ctr2_taken", 32'(lk_taken), 32'd1);

        // Same-cycle lookup/update: old target visible until the edge
        up_valid = 1'b1; up_pc = 32'h40; up_is_jump = 1'b0; up_taken = 1'b1;
        up_target = 32'h140; up_mispredict = 1'b0;
        look(32'h40);
        check("coll_old_target", lk_target, 32'h100);
        @(posedge clk); #1;
        up_valid = 1'b0;
        look(32'h40);
        check("coll_new_target", lk_target, 32'h140);

        // Tag alias at index 0
        update(32'h80, 1'b0, 1'b1, 32'h300, 1'b0);
        look(32'h40);
        check("alias_old_hit", 32'(lk_hit), 32'd0);
        look(32'h80);
        check("alias_new_hit", 32'(lk_hit), 32'd1);
        check("alias_new_target", lk_target, 32'h300);

        // Jump stays predicted taken despite not-taken updates
        update(32'h44, 1'b1, 1'b1, 32'h200, 1'b0);
        for (int i = 0; i < 3; i++) update(32'h44, 1'b1, 1'b0, 32'h0, 1'b0);
        look(32'h44);
        check("jump_hit", 32'(lk_hit), 32'd1);
        check("jump_taken", 32'(lk_taken), 32'd1);
        check("jump_target", lk_target, 32'h200);

        // Flush with concurrent update: update dropped, counter kept
        flush_tbl = 1'b1;
        update(32'h48, 1'b0, 1'b1, 32'h400, 1'b0);
        flush_tbl = 1'b0;
        look(32'h80);
        check("flush_hit_80", 32'(lk_hit), 32'd0);
        look(32'h44);
        check("flush_hit_44", 32'(lk_hit), 32'd0);
        look(32'h48);
        check("flush_drop_48", 32'(lk_hit), 32'd0);
        check("flush_cnt", 32'(mispredict_cnt), 32'd1);

        // Mispredict counter saturation at 15
        for (int i = 0; i < 14; i++) update(32'h4C, 1'b0, 1'b0, 32'h0, 1'b1);
        check("cnt_15", 32'(mispredict_cnt), 32'd15);
        for (int i = 0; i < 2; i++) update(32'h4C, 1'b0, 1'b0, 32'h0, 1'b1);
        check("cnt_sat", 32'(mispredict_cnt), 32'd15);

        // Async reset mid-cycle with an update in flight
        update(32'h50, 1'b0, 1'b1, 32'h500, 1'b0);
        look(32'h50);
        check("pre_rst_hit", 32'(lk_hit), 32'd1);
        #2;
        up_valid = 1'b1; up_pc = 32'h54; up_is_jump = 1'b0; up_taken = 1'b1;
        up_target = 32'h540;
        reset = 1'b1;
        #1;
        check("arst_hit", 32'(lk_hit), 32'd0);
        check("arst_taken", 32'(lk_taken), 32'd0);
        check("arst_target", lk_target, 32'd0);
        check("arst_cnt", 32'(mispredict_cnt), 32'd0);
        @(posedge clk); #1;
        up_valid = 1'b0;
        reset = 1'b0;
        look(32'h54);
        check("arst_lost_upd", 32'(lk_hit), 32'd0);
        look(32'h50);
        check("arst_cleared", 32'(lk_hit), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch target buffer (BTB) with a table of 2-bit saturating counters.
- The pipeline datapath currently assumes every branch is not taken and flushes on each taken branch; this block replaces that assumption.
- Lookup is combinational from the fetch-stage PC and drives next-PC selection in the same cycle.
- Update comes from the execute stage when a branch or jump resolves. A mispredict performance counter is included.

Parameters:
- XLEN, 32, address and target width in bits.
- ENTRIES, 16, BTB/counter table depth; power of two, minimum 4.
- GHR_W, 4, global history width; used only under GSHARE_EN, must be <= log2(ENTRIES).
- CNT_W, 32, width of the mispredict counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- flush_tbl  in  1  synchronous clear of all valid bits.
- lk_pc  in  XLEN  fetch-stage PC to look up.
- lk_hit  out  1  a valid entry with a matching tag exists.
- lk_taken  out  1  predict taken.
- lk_target  out  XLEN  predicted target.
- up_valid  in  1  execute stage resolved a control-flow instruction this cycle.
- up_pc  in  XLEN  PC of the resolved instruction.
- up_is_jump  in  1  1 = unconditional jal/jalr, 0 = conditional branch.
- up_taken  in  1  actual outcome.
- up_target  in  XLEN  actual target.
- up_mispredict  in  1  the pipeline flushed for this instruction.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Address fields:
  - IDX_W = log2(ENTRIES).
  - index = pc[IDX_W+1:2].
  - tag = pc[XLEN-1:IDX_W+2].
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target (XLEN bits), jump flag, 2-bit counter ctr.
- Lookup (combinational, zero latency):
  - lk_hit = valid[idx] && tag match.
  - lk_taken = lk_hit && (jump[idx] || ctr[idx][1]).
  - lk_target = target[idx] when lk_hit, else 0.
- Update (registered, applied on the clk edge when up_valid = 1):
  - Hit, up_taken = 1: ctr increments, saturating at 3; target <= up_target; jump <= up_is_jump.
  - Hit, up_taken = 0: ctr decrements, saturating at 0. Entry stays valid.
  - Miss, up_taken = 1: allocate (replace) the entry at that index; valid = 1, tag and target written; ctr = 2 (weakly taken) for a branch, 3 for a jump.
  - Miss, up_taken = 0: no change.
- Lookup and update to the same index in the same cycle: the lookup returns pre-update values. Write-through bypass is not permitted.
- flush_tbl:
  - Clears every valid bit at the next edge; ctr and target are left unchanged.
  - Has priority over a simultaneous update, which is dropped.
  - mispredict_cnt is not affected.
- mispredict_cnt increments by 1 on each edge with up_valid && up_mispredict, and saturates at all-ones.
- Reset (asynchronous): all valid = 0, ctr = 1, target = 0, jump = 0, mispredict_cnt = 0.
- Outputs while in reset: lk_hit = 0, lk_taken = 0, lk_target = 0.
- Reset asserted mid-update: the update is lost and the table is cleared.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- When defined:
  - A GHR_W-bit global history register ghr (reset 0) is added.
  - Counter index = pc index XOR zero-extended ghr, for both lookup and update.
  - The BTB tag, target, valid and jump fields stay PC-indexed.
  - ghr <= {ghr[GHR_W-2:0], up_taken} on each up_valid edge with up_is_jump = 0.
  - History is non-speculative; flush_tbl does not clear ghr.
- When not defined: no ghr; the counter index equals the BTB index. Behaviour is exactly as above.

Test Plan:
- Reset, then lk_pc = 0x40 -> lk_hit = 0, lk_taken = 0, lk_target = 0, mispredict_cnt = 0.
- Branch allocation and counter walk:
  - up_valid, up_pc = 0x40, branch, taken, target 0x100, mispredict = 1 -> next cycle lk_pc = 0x40 gives hit = 1, taken = 1, target 0x100; mispredict_cnt = 1.
  - Two further not-taken updates -> ctr 2→1→0; lk_taken = 0, lk_hit stays 1.
  - A third not-taken update -> ctr stays 0.
- Tag alias (ENTRIES = 16): after allocating 0x40, a taken update at 0x80 (same index 0, different tag) -> lookup 0x40 gives hit = 0; lookup 0x80 gives hit = 1, target = new value.
- Jump allocation: taken jump at 0x44, target 0x200, followed by 3 not-taken updates at 0x44 -> lk_taken stays 1 (jump flag set).
- Same-cycle collision and flush:
  - Lookup 0x40 while updating 0x40 in the same cycle -> old values seen that cycle, new values the next cycle.
  - flush_tbl together with up_valid -> all lk_hit = 0 afterwards; the update is dropped.
- Counter saturation and async reset:
  - Force mispredict_cnt to all-ones (CNT_W = 4, 16 mispredicts) -> holds at 15.
  - Async reset asserted mid-cycle -> outputs go to 0 immediately.
